// File: rtl/seg_scan_reader.sv
// seg_scan_reader
//   Passive readback monitor for a multiplexed, active-low seven-segment bus.
//   Each anode/cathode pair is registered, checked for a valid single-digit
//   select, and qualified by a stability counter. A stable pair is decoded
//   back into a 5-bit display code (0x00-0x0F hex, 0x10 blank, 0x11 minus,
//   0x1F unrecognised) and written into its digit slot. When every position
//   has been captured since the last frame, frame_valid pulses.
//
// Optional feature macro: SEG_SCAN_READER_ERRCNT_EN
//   defined   : err_count counts decode_err pulses, saturating at 255
//   undefined : err_count is tied to zero
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   an          anode lines, active-low, bit i selects digit i
//   seg         cathode lines, active-low, bit 6 = a ... bit 0 = g
//   digits      captured codes, digit i at [5i+4:5i]
//   frame_valid one-cycle pulse when a full frame has been captured
//   decode_err  one-cycle pulse when an unrecognised pattern is accepted
//   err_count   saturating decode error count (zero when feature disabled)
module seg_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [5*NUM_DIGITS-1:0] digits,
  output logic                    frame_valid,
  output logic                    decode_err,
  output logic [7:0]              err_count
);

  // The counter starts at 0 on the edge that first sees a new pair, so the
  // accept edge is the one where it already holds STABLE_CYCLES-2.
  localparam logic [7:0] ACC_CNT = 8'(STABLE_CYCLES - 2);

  typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HOLD} state_t;

  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b0000001: return 5'h00;
      7'b1001111: return 5'h01;
      7'b0010010: return 5'h02;
      7'b0000110: return 5'h03;
      7'b1001100: return 5'h04;
      7'b0100100: return 5'h05;
      7'b0100000: return 5'h06;
      7'b0001111: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0000100: return 5'h09;
      7'b0001000: return 5'h0A;
      7'b1100000: return 5'h0B;
      7'b0110001: return 5'h0C;
      7'b1000010: return 5'h0D;
      7'b0110000: return 5'h0E;
      7'b0111000: return 5'h0F;
      7'b1111111: return 5'h10;
      7'b1111110: return 5'h11;
      default:    return 5'h1F;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [NUM_DIGITS-1:0] an_p0, an_p1;
  logic [6:0]            seg_p0, seg_p1;
  logic [NUM_DIGITS-1:0] nsel_p0, nsel_m1_p0, mask, mask_mrg;
  logic                  vld_p0, chg_p0;
  logic [4:0]            code_p0;
  state_t                state, state_nx;
  logic [7:0]            cnt;
  logic                  accept, cnt_clr, cnt_inc;

  // ---- stage p0: input register; stage p1: previous pair for change detect
  // The select lines reset to "nothing selected" so the first valid select
  // after reset is always seen as a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p0 <= '1;
      an_p1 <= '1;
    end else begin
      an_p0 <= an;
      an_p1 <= an_p0;
    end
  end

  always_ff @(posedge clk) begin
    seg_p0 <= seg;
    seg_p1 <= seg_p0;
  end

  // Valid select: exactly one anode low, i.e. nsel is one-hot.
  always_comb begin
    nsel_p0    = ~an_p0;
    nsel_m1_p0 = nsel_p0 - NUM_DIGITS'(1);
    vld_p0     = (|nsel_p0) && !(|(nsel_p0 & nsel_m1_p0));
    chg_p0     = (an_p0 != an_p1) || (seg_p0 != seg_p1);
    code_p0    = seg_decode(seg_p0);
    mask_mrg   = mask | nsel_p0;
  end

  // ---- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!vld_p0) begin
      state_nx = S_WAIT;
    end else begin
      case (state)
        S_WAIT:   state_nx = S_SETTLE;
        S_SETTLE: if (!chg_p0 && cnt == ACC_CNT) state_nx = S_HOLD;
        S_HOLD:   if (chg_p0) state_nx = S_SETTLE;
        default:  state_nx = S_WAIT;
      endcase
    end
  end

  always_comb begin
    accept  = 1'b0;
    cnt_clr = 1'b1;
    cnt_inc = 1'b0;
    if (state == S_SETTLE && vld_p0 && !chg_p0) begin
      cnt_clr = 1'b0;
      if (cnt == ACC_CNT) accept  = 1'b1;
      else                cnt_inc = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= 8'd0;
    else if (cnt_clr) cnt <= 8'd0;
    else if (cnt_inc) cnt <= cnt + 8'd1;
  end

  // ---- capture: slot write, seen-mask, frame and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= {NUM_DIGITS{5'h10}};
      mask        <= '0;
      frame_valid <= 1'b0;
      decode_err  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      decode_err  <= 1'b0;
      if (accept) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (nsel_p0[i]) digits[5*i +: 5] <= code_p0;
        end
        if (&mask_mrg) begin
          frame_valid <= 1'b1;
          mask        <= '0;
        end else begin
          mask <= mask_mrg;
        end
        decode_err <= (code_p0 == 5'h1F);
      end
    end
  end

`ifdef SEG_SCAN_READER_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             err_cnt_q <= 8'd0;
    else if (accept && code_p0 == 5'h1F)    err_cnt_q <= sat_inc(err_cnt_q);
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule
